// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory-access controller: state encodings,
// latency limits, counter width and a latency-to-count helper.
package mem_ctrl_pkg;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_READ_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE      = 2'd2;

  localparam int RAM_LAT_MAX = 4;
  localparam int CNT_W       = 3;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    IDLE      = ST_IDLE,
    READ_WAIT = ST_READ_WAIT,
    DONE      = ST_DONE
  } state_t;

  // Clamp a latency parameter into 1..RAM_LAT_MAX so a bad override can
  // never leave the controller stuck waiting on a counter that never expires.
  function automatic cnt_t lat_to_count(input int lat);
    int clamped;
    clamped = lat;
    if (clamped < 1) clamped = 1;
    if (clamped > RAM_LAT_MAX) clamped = RAM_LAT_MAX;
    return cnt_t'(clamped);
  endfunction

endpackage

// File: rtl/mem_access_ctrl_lat_counter.sv
// Loadable down-counter used to time the RAM read latency.
// 'last' is high while the count is 1, i.e. the next decrement reaches 0.
module mem_lat_counter
  import mem_ctrl_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  cnt_t load_value,
  input  logic dec,
  output logic zero,
  output logic last
);

  cnt_t count;

  // Count register: load has priority, decrement saturates at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - cnt_t'(1);
    end
  end

  assign zero = (count == '0);
  assign last = (count == cnt_t'(1));

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-access controller: issues single-cycle stores, and for loads waits
// the RAM read latency, captures the returned word and pulses the writeback
// strobe with the LDR mux select.
// Optional build macro: MEM_ALIGN_CHECK_EN enables misaligned-address
// rejection with a one-cycle fault pulse; without it fault is tied low.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int RAM_LAT = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              op_ldr,
  input  logic              op_str,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] store_data,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-3:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] ram_result,
  output logic              sel_ldr_mux,
  output logic              wb_valid,
  output logic              busy,
  output logic              fault
);

  state_t state;
  state_t next_state;

  logic req_ldr;
  logic req_str;
  logic misaligned;
  logic cnt_load;
  logic cnt_dec;
  logic cnt_zero;
  logic cnt_last;
  logic capture;
  logic fault_next;

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = (addr[1:0] != 2'b00);
`else
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^addr[1:0];
  assign misaligned      = 1'b0;
`endif

  // Only a request with exactly one opcode is a legal access.
  assign req_ldr = start & op_ldr & ~op_str;
  assign req_str = start & op_str & ~op_ldr;

  assign ram_addr  = addr[ADDR_W-1:2];
  assign ram_wdata = store_data;
  assign busy      = (state != IDLE);

  mem_lat_counter u_lat_counter (
    .clk        (clk),
    .reset      (reset),
    .load       (cnt_load),
    .load_value (lat_to_count(RAM_LAT)),
    .dec        (cnt_dec),
    .zero       (cnt_zero),
    .last       (cnt_last)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic and the combinational RAM strobes.
  always_comb begin
    next_state = state;
    ram_en     = 1'b0;
    ram_we     = 1'b0;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    capture    = 1'b0;
    fault_next = 1'b0;
    case (state)
      IDLE: begin
        if (!reset) begin
          if ((req_ldr || req_str) && misaligned) begin
            fault_next = 1'b1;
          end else if (req_ldr) begin
            ram_en     = 1'b1;
            cnt_load   = 1'b1;
            next_state = READ_WAIT;
          end else if (req_str) begin
            ram_en = 1'b1;
            ram_we = 1'b1;
          end
        end
      end
      READ_WAIT: begin
        cnt_dec = 1'b1;
        if (cnt_last || cnt_zero) begin
          capture    = 1'b1;
          next_state = DONE;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Capture register and registered writeback/fault strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ram_result  <= '0;
      sel_ldr_mux <= 1'b0;
      wb_valid    <= 1'b0;
      fault       <= 1'b0;
    end else begin
      if (capture) begin
        ram_result <= ram_rdata;
      end
      sel_ldr_mux <= capture;
      wb_valid    <= capture;
      fault       <= fault_next;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: stimulus pushes expected RAM accesses
// and expected load results; monitors pop and compare when the DUT presents
// ram_en or wb_valid. Includes a latency-accurate RAM model.
module tb_mem_access_ctrl;

  localparam int RAM_LAT = 2;

  typedef struct {
    logic        we;
    logic [29:0] waddr;
    logic [31:0] wdata;
  } acc_t;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } ld_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        op_ldr = 1'b0;
  logic        op_str = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] store_data = '0;
  logic        ram_en;
  logic        ram_we;
  logic [29:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic [31:0] ram_result;
  logic        sel_ldr_mux;
  logic        wb_valid;
  logic        busy;
  logic        fault;

  int checks = 0;
  int failures = 0;
  int cycle = 0;

  acc_t acc_q[$];
  ld_t  ld_q[$];

  logic [31:0] wr_mem [256];
  logic        wr_vld [256];
  logic        pv [RAM_LAT];
  logic [31:0] pd [RAM_LAT];

  mem_access_ctrl #(.RAM_LAT(RAM_LAT), .ADDR_W(32), .DATA_W(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op_ldr      (op_ldr),
    .op_str      (op_str),
    .addr        (addr),
    .store_data  (store_data),
    .ram_en      (ram_en),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata),
    .ram_result  (ram_result),
    .sel_ldr_mux (sel_ldr_mux),
    .wb_valid    (wb_valid),
    .busy        (busy),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  // Cycle counter used to time-stamp expected writebacks.
  always @(posedge clk) cycle++;

  // Unwritten words: word 4 holds DEADBEEF, others A000_0000 + index.
  function automatic logic [31:0] modelRead(input logic [7:0] idx);
    if (wr_vld[idx]) return wr_mem[idx];
    if (idx == 8'd4) return 32'hDEAD_BEEF;
    return 32'hA000_0000 + {24'd0, idx};
  endfunction

  // RAM model: samples the request at the clock edge, data valid RAM_LAT cycles later.
  always @(posedge clk) begin
    pv[0] <= ram_en && !ram_we;
    pd[0] <= modelRead(ram_addr[7:0]);
    for (int i = 1; i < RAM_LAT; i++) begin
      pv[i] <= pv[i-1];
      pd[i] <= pd[i-1];
    end
    if (reset) begin
      for (int i = 0; i < 256; i++) wr_vld[i] <= 1'b0;
    end else if (ram_en && ram_we) begin
      wr_mem[ram_addr[7:0]] <= ram_wdata;
      wr_vld[ram_addr[7:0]] <= 1'b1;
    end
  end

  assign ram_rdata = pv[RAM_LAT-1] ? pd[RAM_LAT-1] : 32'hBAD0_BAD0;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  // Access monitor: every ram_en must match the oldest expected access.
  always @(negedge clk) begin
    if (!reset) begin
      if (ram_en) begin
        if (acc_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_access actual=ram_en addr=%0h expected=none", ram_addr);
        end else begin
          acc_t e;
          e = acc_q.pop_front();
          checkOutput("ram_we", 64'(ram_we), 64'(e.we));
          checkOutput("ram_addr", 64'(ram_addr), 64'(e.waddr));
          checkOutput("ram_wdata", 64'(ram_wdata), 64'(e.wdata));
        end
      end else if (ram_we) begin
        checks++;
        failures++;
        $display("[TB] FAIL we_without_en actual=1 expected=0");
      end
    end
  end

  // Writeback monitor: every wb_valid must match the oldest expected load.
  always @(negedge clk) begin
    if (!reset) begin
      if (wb_valid) begin
        if (ld_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_wb actual=wb_valid expected=none");
        end else begin
          ld_t e;
          e = ld_q.pop_front();
          checkOutput("wb_data", 64'(ram_result), 64'(e.data));
          checkOutput("wb_cycle", 64'(cycle), 64'(e.cyc));
          checkOutput("wb_sel", 64'(sel_ldr_mux), 64'd1);
        end
      end else if (sel_ldr_mux) begin
        checks++;
        failures++;
        $display("[TB] FAIL sel_without_wb actual=1 expected=0");
      end
    end
  end

  // Drive one request for one cycle; caller is aligned just after a rising edge.
  task automatic applyStimulus(input logic ldr, input logic str, input logic [31:0] a,
                               input logic [31:0] d, input bit exp_acc, input bit exp_load,
                               input logic [31:0] exp_data, input logic exp_busy);
    start = 1'b1;
    op_ldr = ldr;
    op_str = str;
    addr = a;
    store_data = d;
    if (exp_acc) acc_q.push_back('{str, a[31:2], d});
    if (exp_load) ld_q.push_back('{exp_data, cycle + RAM_LAT + 1});
    @(negedge clk);
    checkOutput("busy_at_start", 64'(busy), 64'(exp_busy));
    @(posedge clk);
    #1;
    start = 1'b0;
    op_ldr = 1'b0;
    op_str = 1'b0;
  endtask

  // Follow a load from T+1 to T+RAM_LAT+2, checking busy each cycle.
  task automatic loadWait();
    for (int k = 1; k <= RAM_LAT + 1; k++) begin
      @(negedge clk);
      checkOutput("busy_during_load", 64'(busy), 64'd1);
      @(posedge clk);
      #1;
    end
    checkOutput("busy_after_load", 64'(busy), 64'd0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_ram_result"}, 64'(ram_result), 64'd0);
    checkOutput({tag, "_sel"}, 64'(sel_ldr_mux), 64'd0);
    checkOutput({tag, "_wb_valid"}, 64'(wb_valid), 64'd0);
    checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
    checkOutput({tag, "_fault"}, 64'(fault), 64'd0);
    checkOutput({tag, "_ram_en"}, 64'(ram_en), 64'd0);
    checkOutput({tag, "_ram_we"}, 64'(ram_we), 64'd0);
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    start = 1'b1;
    op_ldr = 1'b1;
    addr = 32'h10;
    repeat (3) @(posedge clk);
    #1;
    checkResetOutputs("reset");
    start = 1'b0;
    op_ldr = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] basic load");
    applyStimulus(1, 0, 32'h0000_0010, 32'h0, 1, 1, 32'hDEAD_BEEF, 0);
    loadWait();

    $display("[TB] single and back-to-back stores");
    applyStimulus(0, 1, 32'h20, 32'h1234_5678, 1, 0, 32'h0, 0);
    applyStimulus(0, 1, 32'h24, 32'hCAFE_F00D, 1, 0, 32'h0, 0);
    applyStimulus(0, 1, 32'h28, 32'h0BAD_C0DE, 1, 0, 32'h0, 0);
    checkOutput("wb_after_store", 64'(wb_valid), 64'd0);
    checkOutput("result_held", 64'(ram_result), 64'hDEAD_BEEF);

    $display("[TB] back-to-back loads of stored data");
    applyStimulus(1, 0, 32'h20, 32'h0, 1, 1, 32'h1234_5678, 0);
    loadWait();
    applyStimulus(1, 0, 32'h28, 32'h0, 1, 1, 32'h0BAD_C0DE, 0);
    loadWait();
    applyStimulus(1, 0, 32'h3C, 32'h0, 1, 1, 32'hA000_000F, 0);
    loadWait();

    $display("[TB] start while busy");
    applyStimulus(1, 0, 32'h14, 32'h0, 1, 1, 32'hA000_0005, 0);
    applyStimulus(1, 0, 32'h18, 32'h0, 0, 0, 32'h0, 1);
    repeat (RAM_LAT) @(posedge clk);
    #1;
    checkOutput("busy_after_ignored", 64'(busy), 64'd0);

    $display("[TB] illegal opcodes");
    applyStimulus(1, 1, 32'h30, 32'h5555_AAAA, 0, 0, 32'h0, 0);
    applyStimulus(0, 0, 32'h30, 32'h5555_AAAA, 0, 0, 32'h0, 0);
    checkOutput("busy_after_illegal", 64'(busy), 64'd0);
    repeat (RAM_LAT + 2) @(posedge clk);
    #1;

    $display("[TB] reset mid-load");
    applyStimulus(1, 0, 32'h40, 32'h0, 1, 1, 32'hA000_0010, 0);
    reset = 1'b1;
    start = 1'b1;
    op_ldr = 1'b1;
    addr = 32'h40;
    #1;
    ld_q.delete();
    checkResetOutputs("midreset");
    @(posedge clk);
    #1;
    start = 1'b0;
    op_ldr = 1'b0;
    reset = 1'b0;
    repeat (RAM_LAT + 4) @(posedge clk);
    #1;
    checkOutput("idle_after_reset", 64'(busy), 64'd0);
    applyStimulus(1, 0, 32'h44, 32'h0, 1, 1, 32'hA000_0011, 0);
    loadWait();

    $display("[TB] misaligned load");
`ifdef MEM_ALIGN_CHECK_EN
    applyStimulus(1, 0, 32'h13, 32'h0, 0, 0, 32'h0, 0);
    @(negedge clk);
    checkOutput("fault_t1", 64'(fault), 64'd1);
    checkOutput("busy_t1", 64'(busy), 64'd0);
    @(negedge clk);
    checkOutput("fault_t2", 64'(fault), 64'd0);
`else
    applyStimulus(1, 0, 32'h13, 32'h0, 1, 1, 32'hDEAD_BEEF, 0);
    @(negedge clk);
    checkOutput("fault_t1", 64'(fault), 64'd0);
    checkOutput("busy_t1", 64'(busy), 64'd1);
    repeat (RAM_LAT + 1) @(posedge clk);
    #1;
`endif

    repeat (4) @(posedge clk);
    #1;
    checkOutput("acc_q_drained", 64'(acc_q.size()), 64'd0);
    checkOutput("ld_q_drained", 64'(ld_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
